// File: rtl/multicycle_control_unit_if.sv
// Shared memory-port handshake between the control FSM and memory.
// master: drives mem_req/mem_we/addr_sel, receives mem_ack.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Control FSM sequencing the multi-cycle 16-bit core.
// Ports: clk, rst (async active-low), i_opcode, i_alu_zero,
//   mem (memory handshake, master), o_pc_wr_en, o_pc_src,
//   o_ir_wr_en, o_alu_src_imm, o_alu_op, o_reg_wr_en, o_wb_sel,
//   o_halted, o_fault, o_state_dbg.
// Option: MULTICYCLE_CTRL_MEM_TIMEOUT_EN enables the mem_ack
//   wait counter and the sticky FAULT state.
module multicycle_control_unit #(
  parameter int OPCODE_LEN  = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_LEN-1:0] i_opcode,
  input  logic                  i_alu_zero,
  multicycle_control_unit_if.master mem,
  output logic                  o_pc_wr_en,
  output logic                  o_pc_src,
  output logic                  o_ir_wr_en,
  output logic                  o_alu_src_imm,
  output logic [2:0]            o_alu_op,
  output logic                  o_reg_wr_en,
  output logic [1:0]            o_wb_sel,
  output logic                  o_halted,
  output logic                  o_fault,
  output logic [3:0]            o_state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_WB_ALU   = 4'd3,
    S_WB_IMM   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd14,
    S_FAULT    = 4'd15
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] w_op;
  logic       w_ack;
  logic       w_timeout;

  assign w_op  = i_opcode[3:0];
  assign w_ack = mem.mem_ack;

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_waiting;

  assign w_waiting = mem.mem_req & ~w_ack;
  // Fires in the wait cycle that brings the count to MEM_TIMEOUT;
  // an ack in that same cycle still completes normally.
  assign w_timeout = w_waiting &
    (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_wait_cnt <= '0;
    else if (w_state_nxt != r_state)
      r_wait_cnt <= '0;
    else if (w_waiting)
      r_wait_cnt <= r_wait_cnt + 1'b1;
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (MEM_TIMEOUT > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_FETCH;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_pc_wr_en    = 1'b0;
    o_pc_src      = 1'b0;
    o_ir_wr_en    = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.addr_sel  = 1'b0;
    o_alu_src_imm = 1'b0;
    o_alu_op      = 3'b000;
    o_reg_wr_en   = 1'b0;
    o_wb_sel      = 2'd0;
    o_halted      = 1'b0;
    o_fault       = 1'b0;
    o_state_dbg   = r_state;

    unique case (r_state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (w_ack) begin
          o_ir_wr_en  = 1'b1;
          o_pc_wr_en  = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        unique case (w_op)
          4'b0001, 4'b0010, 4'b0011,
          4'b0100, 4'b0101, 4'b0110,
          4'b0111: w_state_nxt = S_EXEC;
          4'b1000,
          4'b1001: w_state_nxt = S_MEM_ADDR;
          4'b1010: w_state_nxt = S_BRANCH;
          4'b1011: w_state_nxt = S_JUMP;
          4'b1100: w_state_nxt = S_WB_IMM;
          4'b1111: w_state_nxt = S_HALT;
          default: w_state_nxt = S_FETCH;
        endcase
      end
      S_EXEC: begin
        o_alu_op    = w_op[2:0];
        w_state_nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        o_reg_wr_en = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_WB_IMM: begin
        o_reg_wr_en = 1'b1;
        o_wb_sel    = 2'd2;
        w_state_nxt = S_FETCH;
      end
      S_MEM_ADDR: begin
        o_alu_op      = 3'b001;
        o_alu_src_imm = 1'b1;
        w_state_nxt   = w_op[0] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem.mem_req   = 1'b1;
        mem.addr_sel  = 1'b1;
        o_alu_op      = 3'b001;
        o_alu_src_imm = 1'b1;
        if (w_ack)
          w_state_nxt = S_MEM_WB;
        else if (w_timeout)
          w_state_nxt = S_FAULT;
      end
      S_MEM_WB: begin
        o_reg_wr_en = 1'b1;
        o_wb_sel    = 2'd1;
        w_state_nxt = S_FETCH;
      end
      S_MEM_WR: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.addr_sel  = 1'b1;
        o_alu_op      = 3'b001;
        o_alu_src_imm = 1'b1;
        if (w_ack)
          w_state_nxt = S_FETCH;
        else if (w_timeout)
          w_state_nxt = S_FAULT;
      end
      S_BRANCH: begin
        o_alu_op    = 3'b010;
        o_pc_wr_en  = i_alu_zero;
        o_pc_src    = i_alu_zero;
        w_state_nxt = S_FETCH;
      end
      S_JUMP: begin
        o_pc_wr_en  = 1'b1;
        o_pc_src    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        o_halted = 1'b1;
      end
      S_FAULT: begin
        o_fault = 1'b1;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Reset blanks every output combinationally, even in FETCH.
    if (!rst) begin
      o_pc_wr_en    = 1'b0;
      o_pc_src      = 1'b0;
      o_ir_wr_en    = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.addr_sel  = 1'b0;
      o_alu_src_imm = 1'b0;
      o_alu_op      = 3'b000;
      o_reg_wr_en   = 1'b0;
      o_wb_sel      = 2'd0;
      o_halted      = 1'b0;
      o_fault       = 1'b0;
      o_state_dbg   = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Expected output vectors queued per cycle, checked by assertions.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       alu_zero;
  logic       pc_wr_en;
  logic       pc_src;
  logic       ir_wr_en;
  logic       alu_src_imm;
  logic [2:0] alu_op;
  logic       reg_wr_en;
  logic [1:0] wb_sel;
  logic       halted;
  logic       fault;
  logic [3:0] state_dbg;

  int checks;
  int errors;

  logic [18:0] exp_q[$];

  multicycle_control_unit_if mif();

  multicycle_control_unit #(
    .OPCODE_LEN (4),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_opcode     (opcode),
    .i_alu_zero   (alu_zero),
    .mem          (mif.master),
    .o_pc_wr_en   (pc_wr_en),
    .o_pc_src     (pc_src),
    .o_ir_wr_en   (ir_wr_en),
    .o_alu_src_imm(alu_src_imm),
    .o_alu_op     (alu_op),
    .o_reg_wr_en  (reg_wr_en),
    .o_wb_sel     (wb_sel),
    .o_halted     (halted),
    .o_fault      (fault),
    .o_state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pc_wr_en pc_src ir_wr_en mem_req mem_we addr_sel
  // alu_src_imm alu_op reg_wr_en wb_sel halted fault state_dbg
  function automatic logic [18:0] v(
    input logic       pcw, pcs, ir, req, we, as, imm,
    input logic [2:0] op,
    input logic       rw,
    input logic [1:0] wb,
    input logic       h, f,
    input logic [3:0] st
  );
    return {pcw, pcs, ir, req, we, as, imm, op, rw, wb, h, f, st};
  endfunction

  logic [18:0] e_zero, e_fw, e_fa, e_dec, e_wba, e_wbi;
  logic [18:0] e_madr, e_mrd, e_mwb, e_mwr, e_br0, e_br1;
  logic [18:0] e_jmp, e_hlt, e_flt, e_ex3;

  task automatic step(
    input logic        r,
    input logic [3:0]  op,
    input logic        z,
    input logic        a,
    input logic [18:0] e,
    input string       tag
  );
    logic [18:0] obs;
    logic [18:0] want;
    @(negedge clk);
    rst          = r;
    opcode       = op;
    alu_zero     = z;
    mif.mem_ack  = a;
    exp_q.push_back(e);
    #1;
    obs = {pc_wr_en, pc_src, ir_wr_en, mif.mem_req,
           mif.mem_we, mif.addr_sel, alu_src_imm,
           alu_op, reg_wr_en, wb_sel, halted, fault,
           state_dbg};
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, want);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    opcode      = 4'd0;
    alu_zero    = 1'b0;
    mif.mem_ack = 1'b0;

    e_zero = '0;
    e_fw   = v(0,0,0,1,0,0,0,3'd0,0,2'd0,0,0,4'd0);
    e_fa   = v(1,0,1,1,0,0,0,3'd0,0,2'd0,0,0,4'd0);
    e_dec  = v(0,0,0,0,0,0,0,3'd0,0,2'd0,0,0,4'd1);
    e_ex3  = v(0,0,0,0,0,0,0,3'd3,0,2'd0,0,0,4'd2);
    e_wba  = v(0,0,0,0,0,0,0,3'd0,1,2'd0,0,0,4'd3);
    e_wbi  = v(0,0,0,0,0,0,0,3'd0,1,2'd2,0,0,4'd4);
    e_madr = v(0,0,0,0,0,0,1,3'd1,0,2'd0,0,0,4'd5);
    e_mrd  = v(0,0,0,1,0,1,1,3'd1,0,2'd0,0,0,4'd6);
    e_mwb  = v(0,0,0,0,0,0,0,3'd0,1,2'd1,0,0,4'd7);
    e_mwr  = v(0,0,0,1,1,1,1,3'd1,0,2'd0,0,0,4'd8);
    e_br0  = v(0,0,0,0,0,0,0,3'd2,0,2'd0,0,0,4'd9);
    e_br1  = v(1,1,0,0,0,0,0,3'd2,0,2'd0,0,0,4'd9);
    e_jmp  = v(1,1,0,0,0,0,0,3'd0,0,2'd0,0,0,4'd10);
    e_hlt  = v(0,0,0,0,0,0,0,3'd0,0,2'd0,1,0,4'd14);
    e_flt  = v(0,0,0,0,0,0,0,3'd0,0,2'd0,0,1,4'd15);

    step(0, 4'd0, 0, 0, e_zero, "reset");
    step(0, 4'd0, 0, 1, e_zero, "reset_ack");

    step(1, 4'd0,  0, 1, e_fa,  "nop_fetch");
    step(1, 4'd0,  0, 1, e_dec, "nop_decode");
    step(1, 4'd11, 0, 1, e_fa,  "jmp_fetch");
    step(1, 4'd11, 0, 1, e_dec, "jmp_decode");
    step(1, 4'd11, 0, 1, e_jmp, "jmp_jump");

    step(1, 4'd3, 0, 1, e_fa,  "alu_fetch");
    step(1, 4'd3, 0, 1, e_dec, "alu_decode");
    step(1, 4'd3, 0, 1, e_ex3, "alu_exec");
    step(1, 4'd3, 0, 1, e_wba, "alu_wb");

    step(1, 4'd8, 0, 1, e_fa,   "ld_fetch");
    step(1, 4'd8, 0, 1, e_dec,  "ld_decode");
    step(1, 4'd8, 0, 1, e_madr, "ld_addr");
    step(1, 4'd8, 0, 0, e_mrd,  "ld_wait1");
    step(1, 4'd8, 0, 0, e_mrd,  "ld_wait2");
    step(1, 4'd8, 0, 0, e_mrd,  "ld_wait3");
    step(1, 4'd8, 0, 1, e_mrd,  "ld_ack");
    step(1, 4'd8, 0, 0, e_mwb,  "ld_wb");

    step(1, 4'd9, 0, 1, e_fa,   "st_fetch");
    step(1, 4'd9, 0, 1, e_dec,  "st_decode");
    step(1, 4'd9, 0, 1, e_madr, "st_addr");
    step(1, 4'd9, 0, 1, e_mwr,  "st_ack");

    step(1, 4'd12, 0, 1, e_fa,  "li_fetch");
    step(1, 4'd12, 0, 1, e_dec, "li_decode");
    step(1, 4'd12, 0, 1, e_wbi, "li_wb");

    step(1, 4'd10, 0, 1, e_fa,  "beq0_fetch");
    step(1, 4'd10, 0, 1, e_dec, "beq0_decode");
    step(1, 4'd10, 0, 1, e_br0, "beq0_branch");
    step(1, 4'd10, 1, 1, e_fa,  "beq1_fetch");
    step(1, 4'd10, 1, 1, e_dec, "beq1_decode");
    step(1, 4'd10, 1, 1, e_br1, "beq1_branch");

    step(1, 4'd13, 0, 0, e_fw,  "undef_wait1");
    step(1, 4'd13, 0, 0, e_fw,  "undef_wait2");
    step(1, 4'd13, 0, 1, e_fa,  "undef_fetch");
    step(1, 4'd13, 0, 1, e_dec, "undef_decode");
    step(1, 4'd13, 0, 1, e_fa,  "undef_refetch");

    step(1, 4'd9, 0, 0, e_dec,  "st2_decode");
    step(1, 4'd9, 0, 0, e_madr, "st2_addr");
    step(1, 4'd9, 0, 0, e_mwr,  "st2_wait1");
    step(1, 4'd9, 0, 0, e_mwr,  "st2_wait2");
    step(0, 4'd9, 0, 0, e_zero, "rst_mid_wr");
    step(1, 4'd0, 0, 0, e_fw,   "rst_release");

    step(1, 4'd15, 0, 1, e_fa,  "halt_fetch");
    step(1, 4'd15, 0, 1, e_dec, "halt_decode");
    for (int i = 0; i < 10; i++)
      step(1, 4'(i * 7), 0, i[0], e_hlt, "halt_hold");

    step(0, 4'd0, 0, 0, e_zero, "reset2");
    step(1, 4'd0, 0, 0, e_fw,   "to_wait1");
    step(1, 4'd0, 0, 0, e_fw,   "to_wait2");
    step(1, 4'd0, 0, 0, e_fw,   "to_wait3");
    step(1, 4'd0, 0, 0, e_fw,   "to_wait4");
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    step(1, 4'd0, 0, 0, e_flt,  "to_fault");
    step(1, 4'd0, 0, 1, e_flt,  "to_sticky1");
    step(1, 4'd5, 0, 0, e_flt,  "to_sticky2");
`else
    step(1, 4'd0, 0, 0, e_fw,   "to_hold1");
    step(1, 4'd0, 0, 0, e_fw,   "to_hold2");
    step(1, 4'd0, 0, 0, e_fw,   "to_hold3");
`endif

    step(0, 4'd0, 0, 0, e_zero, "reset3");
    step(1, 4'd0, 0, 0, e_fw,   "ackwin_w1");
    step(1, 4'd0, 0, 0, e_fw,   "ackwin_w2");
    step(1, 4'd0, 0, 0, e_fw,   "ackwin_w3");
    step(1, 4'd0, 0, 1, e_fa,   "ackwin_ack");
    step(1, 4'd0, 0, 0, e_dec,  "ackwin_decode");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
